// File: rtl/bar_scan.sv
// bar_scan: counts black bars on three fixed scan rows of a video frame and
// flags a valid barcode when all three rows agree and carry enough bars.
// Optional feature macro BAR_SCAN_WIDTH_CHECK_EN adds a widest/narrowest
// black-run ratio check on row 1; without it the width registers are absent.
module bar_scan #(
  parameter logic [9:0] ROW_Y1    = 10'd2,
  parameter logic [9:0] ROW_Y2    = 10'd7,
  parameter logic [9:0] ROW_Y3    = 10'd12,
  parameter logic [7:0] MIN_BARS  = 8'd4,
  parameter int         MAX_RATIO = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic       in_vs,
  input  logic       in_de,
  input  logic       in_data,
  output logic       scan_en,
  output logic [7:0] bar_cnt,
  output logic       scan_done
);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_EVAL = 2'd3;

  logic [1:0] state;
  logic [1:0] ri;
  logic [7:0] row_cnt;
  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic [7:0] cnt2;
  logic       prev_px;
  logic       vs_prev;
  logic       evt_q;
  logic [9:0] target_y;
  logic       row_start;
  logic       vs_rise;
  logic       width_ok;
  logic       frame_ok;
  logic       unused_sig;

  // The pixel x coordinate is not needed: rows are delimited by in_de.
  assign unused_sig = ^{x_in, 32'(MAX_RATIO)};

  assign vs_rise   = in_vs & ~vs_prev;
  assign row_start = in_de && (y_in == target_y);

  // Select the y coordinate of the row currently being waited for.
  always_comb begin
    target_y = ROW_Y3;
    case (ri)
      2'd0:    target_y = ROW_Y1;
      2'd1:    target_y = ROW_Y2;
      default: target_y = ROW_Y3;
    endcase
  end

  // Edge detection stage: vs history and a registered "evaluate now" event,
  // which gives the row logic one cycle to store a row ending on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      vs_prev <= in_vs;
      evt_q   <= vs_rise;
    end
  end

  // Row scanning FSM: wait for a target row, count rising black edges, store
  // the count when the row ends, and reset everything after an evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_WAIT;
      ri      <= 2'd0;
      row_cnt <= 8'd0;
      cnt0    <= 8'd0;
      cnt1    <= 8'd0;
      cnt2    <= 8'd0;
      prev_px <= 1'b0;
    end else if (evt_q) begin
      state <= S_EVAL;
    end else begin
      case (state)
        S_WAIT: begin
          if (row_start) begin
            state   <= S_SCAN;
            row_cnt <= {7'd0, in_data};
            prev_px <= in_data;
          end
        end
        S_SCAN: begin
          if (in_de) begin
            prev_px <= in_data;
            if (in_data && !prev_px && (row_cnt != 8'hFF)) begin
              row_cnt <= row_cnt + 8'd1;
            end
          end else begin
            case (ri)
              2'd0:    cnt0 <= row_cnt;
              2'd1:    cnt1 <= row_cnt;
              default: cnt2 <= row_cnt;
            endcase
            row_cnt <= 8'd0;
            prev_px <= 1'b0;
            if (ri == 2'd2) begin
              state <= S_HOLD;
            end else begin
              ri    <= ri + 2'd1;
              state <= S_WAIT;
            end
          end
        end
        S_HOLD: begin
          state <= S_HOLD;
        end
        default: begin
          state   <= S_WAIT;
          ri      <= 2'd0;
          row_cnt <= 8'd0;
          cnt0    <= 8'd0;
          cnt1    <= 8'd0;
          cnt2    <= 8'd0;
          prev_px <= 1'b0;
        end
      endcase
    end
  end

`ifdef BAR_SCAN_WIDTH_CHECK_EN
  logic [9:0]  run_len;
  logic [9:0]  run_inc;
  logic [9:0]  w_min;
  logic [9:0]  w_max;
  logic        w_any;
  logic        close_run;
  logic [19:0] ratio_lim;

  assign run_inc   = (run_len == 10'h3FF) ? run_len : run_len + 10'd1;
  assign close_run = (state == S_SCAN) && (ri == 2'd0) && prev_px &&
                     (!in_de || !in_data);
  assign ratio_lim = 20'(MAX_RATIO) * {10'd0, w_min};
  assign width_ok  = w_any && ({10'd0, w_max} <= ratio_lim);

  // Measure black run lengths on row 1 and keep the narrowest and widest;
  // a run still open when the row ends is closed by the in_de fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_len <= 10'd0;
      w_min   <= 10'd0;
      w_max   <= 10'd0;
      w_any   <= 1'b0;
    end else if (evt_q) begin
      run_len <= run_len;
    end else if (state == S_EVAL) begin
      run_len <= 10'd0;
      w_min   <= 10'd0;
      w_max   <= 10'd0;
      w_any   <= 1'b0;
    end else if ((state == S_WAIT) && row_start && (ri == 2'd0)) begin
      run_len <= in_data ? 10'd1 : 10'd0;
    end else if ((state == S_SCAN) && (ri == 2'd0)) begin
      if (in_de && in_data) begin
        run_len <= prev_px ? run_inc : 10'd1;
      end
      if (close_run) begin
        if (!w_any) begin
          w_min <= run_len;
          w_max <= run_len;
          w_any <= 1'b1;
        end else begin
          if (run_len < w_min) w_min <= run_len;
          if (run_len > w_max) w_max <= run_len;
        end
      end
    end
  end
`else
  assign width_ok = 1'b1;
`endif

  assign frame_ok = (state == S_HOLD) && (cnt0 == cnt1) && (cnt1 == cnt2) &&
                    (cnt0 >= MIN_BARS) && width_ok;

  // Frame result registers: loaded as the FSM enters evaluation, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_en   <= 1'b0;
      bar_cnt   <= 8'd0;
      scan_done <= 1'b0;
    end else if (evt_q) begin
      scan_en   <= frame_ok;
      bar_cnt   <= cnt0;
      scan_done <= 1'b1;
    end else begin
      scan_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bar_scan.sv
// tb_bar_scan: drives whole frames of pixels into bar_scan and compares the
// per-frame result against bar counts computed directly from the row images.
module tb_bar_scan;

  localparam int         W      = 48;
  localparam int         NLINES = 16;
  localparam logic [9:0] Y1     = 10'd2;
  localparam logic [9:0] Y2     = 10'd7;
  localparam logic [9:0] Y3     = 10'd12;
  localparam int         MINB   = 4;
  localparam int         RATIO  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] x_in;
  logic [9:0] y_in;
  logic       in_vs;
  logic       in_de;
  logic       in_data;
  logic       scan_en;
  logic [7:0] bar_cnt;
  logic       scan_done;

  int checkCount = 0;
  int errorCount = 0;

  logic [W-1:0] rowPat [3];
  logic         holdEn;
  logic [7:0]   holdCnt;

  bar_scan #(
    .ROW_Y1(Y1), .ROW_Y2(Y2), .ROW_Y3(Y3), .MIN_BARS(8'(MINB)), .MAX_RATIO(RATIO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .y_in(y_in),
    .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
    .scan_en(scan_en), .bar_cnt(bar_cnt), .scan_done(scan_done)
  );

  // Free-running pixel clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int countBars(input logic [W-1:0] pat);
    int   c = 0;
    logic prev = 1'b0;
    for (int p = 0; p < W; p++) begin
      if (pat[p] && !prev) c++;
      prev = pat[p];
    end
    if (c > 255) c = 255;
    return c;
  endfunction

  function automatic bit widthOk(input logic [W-1:0] pat);
    int lens[$];
    int len = 0;
    int mn;
    int mx;
    for (int p = 0; p < W; p++) begin
      if (pat[p]) len++;
      else if (len > 0) begin
        lens.push_back(len);
        len = 0;
      end
    end
    if (len > 0) lens.push_back(len);
    if (lens.size() == 0) return 1'b0;
    mn = lens[0];
    mx = lens[0];
    foreach (lens[i]) begin
      if (lens[i] < mn) mn = lens[i];
      if (lens[i] > mx) mx = lens[i];
    end
    return mx <= RATIO * mn;
  endfunction

  function automatic int rowOf(input int y);
    if (y == int'(Y1)) return 0;
    if (y == int'(Y2)) return 1;
    if (y == int'(Y3)) return 2;
    return -1;
  endfunction

  function automatic logic [W-1:0] makeBars(input int n, input int barW, input int gapW);
    logic [W-1:0] pat = '0;
    int p = 0;
    for (int b = 0; b < n; b++) begin
      p += gapW;
      for (int i = 0; i < barW; i++) begin
        if (p < W) pat[p] = 1'b1;
        p++;
      end
    end
    return pat;
  endfunction

  function automatic logic [W-1:0] makeAlt(input int a, input int b);
    logic [W-1:0] pat = '0;
    int p = 0;
    int widths[4];
    widths = '{a, b, a, b};
    for (int k = 0; k < 4; k++) begin
      p += 2;
      for (int i = 0; i < widths[k]; i++) begin
        if (p < W) pat[p] = 1'b1;
        p++;
      end
    end
    return pat;
  endfunction

  function automatic logic [W-1:0] randPat();
    logic [W-1:0] pat = '0;
    logic v = 1'b0;
    for (int p = 0; p < W; p++) begin
      if ($urandom_range(0, 2) == 0) v = ~v;
      pat[p] = v;
    end
    return pat;
  endfunction

  task automatic setAll(input logic [W-1:0] pat);
    for (int k = 0; k < 3; k++) rowPat[k] = pat;
  endtask

  // Raise vsync and check the exact two-cycle latency and the frame result.
  task automatic vsSequence(input bit keepDe, input bit expEn, input logic [7:0] expCnt);
    checkOutput("hold_en", {31'd0, scan_en}, {31'd0, holdEn});
    checkOutput("hold_cnt", {24'd0, bar_cnt}, {24'd0, holdCnt});
    @(negedge clk);
    in_vs = 1'b1;
    in_de = keepDe;
    @(posedge clk); #1;
    checkOutput("done_early", {31'd0, scan_done}, 32'd0);
    @(negedge clk);
    in_de = 1'b0;
    @(posedge clk); #1;
    checkOutput("done_pulse", {31'd0, scan_done}, 32'd1);
    checkOutput("scan_en", {31'd0, scan_en}, {31'd0, expEn});
    checkOutput("bar_cnt", {24'd0, bar_cnt}, {24'd0, expCnt});
    @(posedge clk); #1;
    checkOutput("done_end", {31'd0, scan_done}, 32'd0);
    @(negedge clk);
    in_vs = 1'b0;
    holdEn  = expEn;
    holdCnt = expCnt;
  endtask

  // Drive one frame from rowPat; optionally abort mid-row or raise vsync as
  // the last scan row ends.
  task automatic applyStimulus(input int abortRow, input int abortPx, input bit sameCycle);
    int c[3];
    bit expEn;
    int k;
    for (int i = 0; i < 3; i++) c[i] = countBars(rowPat[i]);
    expEn = (c[0] == c[1]) && (c[1] == c[2]) && (c[0] >= MINB);
`ifdef BAR_SCAN_WIDTH_CHECK_EN
    expEn = expEn && widthOk(rowPat[0]);
`endif
    for (int y = 0; y < NLINES; y++) begin
      k = rowOf(y);
      for (int px = 0; px < W; px++) begin
        @(negedge clk);
        in_de = 1'b1;
        x_in  = 10'(px);
        y_in  = 10'(y);
        in_data = (k >= 0) ? rowPat[k][px] : 1'($urandom_range(0, 1));
        if ((k >= 0) && (k == abortRow) && (px == abortPx)) begin
          vsSequence(1'b1, 1'b0, (abortRow > 0) ? 8'(c[0]) : 8'd0);
          return;
        end
      end
      if (sameCycle && (k == 2)) begin
        vsSequence(1'b0, expEn, 8'(c[0]));
        return;
      end
      for (int b = 0; b < 3; b++) begin
        @(negedge clk);
        in_de = 1'b0;
      end
    end
    vsSequence(1'b0, expEn, 8'(c[0]));
  endtask

  initial begin
    int abortRow;
    bit sameCycle;
    rst_n = 1'b0; x_in = '0; y_in = '0; in_vs = 1'b0; in_de = 1'b0; in_data = 1'b0;
    holdEn = 1'b0; holdCnt = 8'd0;
    #12;
    checkOutput("rst_en", {31'd0, scan_en}, 32'd0);
    checkOutput("rst_cnt", {24'd0, bar_cnt}, 32'd0);
    checkOutput("rst_done", {31'd0, scan_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    setAll(makeBars(6, 4, 4));
    applyStimulus(-1, 0, 1'b0);

    setAll(makeBars(6, 4, 4));
    rowPat[1] = makeBars(5, 4, 4);
    applyStimulus(-1, 0, 1'b0);

    setAll(makeBars(3, 4, 4));
    applyStimulus(-1, 0, 1'b0);

    setAll(makeBars(6, 4, 4));
    applyStimulus(1, 20, 1'b0);
    applyStimulus(-1, 0, 1'b0);

    setAll('1);
    applyStimulus(-1, 0, 1'b0);
    setAll(makeAlt(2, 10));
    applyStimulus(-1, 0, 1'b0);
    setAll(makeAlt(2, 8));
    applyStimulus(-1, 0, 1'b0);

    setAll(makeBars(6, 4, 4));
    applyStimulus(-1, 0, 1'b1);

    // Reset pulsed in the middle of row 1 of a new frame.
    for (int px = 0; px < 16; px++) begin
      @(negedge clk);
      in_de = 1'b1; x_in = 10'(px); y_in = Y1; in_data = rowPat[0][px];
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_en", {31'd0, scan_en}, 32'd0);
    checkOutput("midrst_cnt", {24'd0, bar_cnt}, 32'd0);
    checkOutput("midrst_done", {31'd0, scan_done}, 32'd0);
    @(negedge clk);
    in_de = 1'b0;
    rst_n = 1'b1;
    holdEn = 1'b0; holdCnt = 8'd0;
    applyStimulus(-1, 0, 1'b0);

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 1) == 0) setAll(randPat());
      else for (int k = 0; k < 3; k++) rowPat[k] = randPat();
      abortRow  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1;
      sameCycle = (abortRow < 0) && ($urandom_range(0, 5) == 0);
      applyStimulus(abortRow, int'($urandom_range(1, W - 2)), sameCycle);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
